fp_sub_seq: RTL and testbench
=============================

FP_SUB_SEQ -- requirements
Module: fp_sub_seq

Interface
REQ-001 The ports SHALL be: clk  in  1  rising-edge clock for all state.
REQ-002 The ports SHALL include reset_n  in  1  asynchronous active-low reset.
REQ-003 The ports SHALL include dataa  in  32  IEEE-754 single minuend.
REQ-004 The ports SHALL include datab  in  32  IEEE-754 single subtrahend.
REQ-005 The ports SHALL include enable  in  1  start request, sampled in IDLE only.
REQ-006 The ports SHALL include result  out  32  registered dataa - datab.
REQ-007 The ports SHALL include done  out  1  one-cycle completion pulse.

Function
REQ-008 The block SHALL compute dataa + (-datab): flip the sign of datab at capture, then run the add-path magnitude compare, swap, align, add/subtract and normalise.
REQ-009 The FSM states SHALL be IDLE, ALIGN, ADDSUB, NORM, PACK, DONE.
REQ-010 At edge k in IDLE with enable=1, dataa and datab SHALL be latched; the inputs need not be held afterwards.
REQ-011 Special cases SHALL go IDLE->DONE at edge k, with result set on the same edge:
- both |a|,|b| zero: 0x00000000
- only b zero: dataa
- only a zero: datab with bit 31 inverted
- either exponent 0xFF: 0x7FC00000
REQ-012 Any exponent of 0 SHALL be treated as zero; denormals are flushed.
REQ-013 ALIGN SHALL order the operands by {exp,mant} (larger first; on a tie, a is larger) and right-shift the smaller {1,mant} by the exponent difference; a difference >=24 SHALL yield 0.
REQ-014 ADDSUB SHALL produce a 25-bit sum if the effective signs match, else a 25-bit difference (big - small).
REQ-015 NORM behaviour SHALL be:
- sum bit24 set: shift right 1, exponent +1, exit in 1 cycle
- else: shift left one bit per cycle, exponent -1 per shift, until bit23=1 (N shifts, N<=23)
- zero sum: exit immediately
REQ-016 Rounding SHALL be truncation; bits shifted out are discarded.
REQ-017 PACK SHALL form {sign_big, exp, mant[22:0]} with the following overrides:
- zero sum -> 0x00000000
- exponent <=0 -> 0x00000000
- exponent >=255 -> {sign, 0xFF, 0}
REQ-018 For a non-special operation, the DONE state SHALL be entered at edge k+4+N, with done=1 for exactly one cycle, then return to IDLE.
REQ-019 result SHALL hold its value until the next operation's PACK or special-case edge.
REQ-020 enable asserted outside IDLE SHALL be ignored, with no queuing.
REQ-021 enable held high SHALL start a new operation on the first IDLE cycle after DONE.

Reset
REQ-022 On reset_n=0, the block SHALL asynchronously force state=IDLE, done=0, result=0x00000000, and clear all datapath registers.
REQ-023 Reset asserted mid-operation SHALL abort the operation, and no done SHALL be produced for it.
REQ-024 The first enable SHALL be accepted at the first rising edge with reset_n=1.

Structure
REQ-025 Shared package fp_pkg SHALL hold the following, reused by the adder family:
- state enum
- EXP_W=8, MANT_W=23, EXP_MAX=8'hFF, QNAN=32'h7FC00000
REQ-026 One combinational sub-module fp_unpack SHALL split a word into sign, exp and mant, and flag is_zero and is_special.
REQ-027 The FSM and datapath registers SHALL live in fp_sub_seq.

Verification
REQ-028 The bench SHALL check 0x40400000 - 0x3F800000 (3.0-1.0) -> result 0x40000000, done at edge k+4.
REQ-029 The bench SHALL check 0x3F800000 - 0xBF800000 (1.0-(-1.0)) -> 0x40000000 (carry path, N=0), done at k+4.
REQ-030 The bench SHALL check 0x3F800000 - 0x3F7FFFFF -> 0x34000000 (truncation, N=23), done at k+27.
REQ-031 The bench SHALL check the zero and cancel cases:
- 0x00000000 - 0x40A00000 -> 0xC0A00000, done at k
- 0x3F800000 - 0x3F800000 -> 0x00000000
REQ-032 The bench SHALL check 0x7F800000 - 0x3F800000 -> 0x7FC00000 at k, and that an enable pulse during NORM is ignored.
REQ-033 The bench SHALL check that reset_n pulsed low during NORM of case REQ-030 gives done=0 and result=0 immediately, and that a following 3.0-1.0 completes normally.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared definitions for the sequential single-precision adder family:
// FSM state encoding and IEEE-754 field widths/constants.
package fp_pkg;

  localparam int          EXP_W   = 8;
  localparam int          MANT_W  = 23;
  localparam logic [7:0]  EXP_MAX = 8'hFF;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADDSUB,
    NORM,
    PACK,
    DONE
  } state_e;

endpackage

// File: rtl/fp_unpack.sv
// Splits an IEEE-754 single into its fields and flags zero (denormals
// flushed) and special (Inf/NaN) encodings.
module fp_unpack
  import fp_pkg::*;
(
  input  logic [31:0]       word,
  output logic              sign,
  output logic [EXP_W-1:0]  exp,
  output logic [MANT_W-1:0] mant,
  output logic              is_zero,
  output logic              is_special
);

  assign sign       = word[31];
  assign exp        = word[30:23];
  assign mant       = word[22:0];
  assign is_zero    = (word[30:23] == '0);
  assign is_special = (word[30:23] == EXP_MAX);

endmodule

// File: rtl/fp_sub_seq.sv
// Multi-cycle IEEE-754 single subtractor: result = dataa + (-datab), with
// flush-to-zero, truncation and one-bit-per-cycle left normalisation.
module fp_sub_seq
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  input  logic        enable,
  output logic [31:0] result,
  output logic        done
);

  state_e             state_q, state_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic [23:0]        big_q, big_d, sml_q, sml_d;
  logic signed [9:0]  exp_q, exp_d;
  logic               sign_q, sign_d, sub_q, sub_d;
  logic [24:0]        sum_q, sum_d;
  logic [31:0]        result_q, result_d;
  logic               done_q, done_d;

  logic [31:0] ua_word, ub_word;
  logic        sa, sb, za, zb, xa, xb;
  logic [7:0]  ea, eb;
  logic [22:0] ma, mb;
  logic        a_big;
  logic [7:0]  diff;
  logic [23:0] m_small;

  // In IDLE the unpackers look at the live inputs (special-case detection);
  // afterwards they look at the captured operands, b already negated.
  assign ua_word = (state_q == IDLE) ? dataa : a_q;
  assign ub_word = (state_q == IDLE) ? {~datab[31], datab[30:0]} : b_q;

  fp_unpack u_unpack_a (
    .word(ua_word), .sign(sa), .exp(ea), .mant(ma), .is_zero(za), .is_special(xa)
  );
  fp_unpack u_unpack_b (
    .word(ub_word), .sign(sb), .exp(eb), .mant(mb), .is_zero(zb), .is_special(xb)
  );

  always_comb begin
    // NOTE: every _d starts from its _q so no path through the case leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    big_d    = big_q;
    sml_d    = sml_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
    sub_d    = sub_q;
    sum_d    = sum_q;
    result_d = result_q;
    done_d   = 1'b0;

    a_big   = ({ea, ma} >= {eb, mb});
    diff    = a_big ? (ea - eb) : (eb - ea);
    m_small = a_big ? {1'b1, mb} : {1'b1, ma};

    case (state_q)
      IDLE: if (enable) begin
        if (za || zb || xa || xb) begin
          state_d = DONE;
          done_d  = 1'b1;
          if (za && zb)      result_d = '0;
          else if (zb)       result_d = dataa;
          else if (za)       result_d = ub_word;
          else               result_d = QNAN;
        end else begin
          a_d     = ua_word;
          b_d     = ub_word;
          state_d = ALIGN;
        end
      end
      ALIGN: begin
        big_d   = a_big ? {1'b1, ma} : {1'b1, mb};
        sml_d   = (diff >= 8'd24) ? 24'd0 : (m_small >> diff);
        exp_d   = $signed({2'b00, (a_big ? ea : eb)});
        sign_d  = a_big ? sa : sb;
        sub_d   = sa ^ sb;
        state_d = ADDSUB;
      end
      ADDSUB: begin
        sum_d   = sub_q ? ({1'b0, big_q} - {1'b0, sml_q})
                        : ({1'b0, big_q} + {1'b0, sml_q});
        state_d = NORM;
      end
      NORM: begin
        if (sum_q == '0) begin
          state_d = PACK;
        end else if (sum_q[24]) begin
          sum_d   = sum_q >> 1;
          exp_d   = exp_q + 10'sd1;
          state_d = PACK;
        end else if (sum_q[23]) begin
          state_d = PACK;
        end else begin
          sum_d = sum_q << 1;
          exp_d = exp_q - 10'sd1;
        end
      end
      PACK: begin
        if (sum_q == '0 || exp_q <= 10'sd0) result_d = '0;
        else if (exp_q >= 10'sd255)         result_d = {sign_q, EXP_MAX, 23'd0};
        else                                result_d = {sign_q, exp_q[7:0], sum_q[22:0]};
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every register, datapath included, is cleared by reset so an
  // aborted operation leaves no residue that a later one could observe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      big_q    <= '0;
      sml_q    <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      sub_q    <= 1'b0;
      sum_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      big_q    <= big_d;
      sml_q    <= sml_d;
      exp_q    <= exp_d;
      sign_q   <= sign_d;
      sub_q    <= sub_d;
      sum_q    <= sum_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;

endmodule

// File: tb/tb_fp_sub_seq.sv
// Self-checking bench for fp_sub_seq: arithmetic reference model plus a
// per-cycle scoreboard of done timing and held result value.
module tb_fp_sub_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] dataa = '0;
  logic [31:0] datab = '0;
  logic        enable = 1'b0;
  logic [31:0] result;
  logic        done;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          done_cyc = -1;
  logic [31:0] pend_res = '0;
  logic [31:0] hold_res = '0;

  fp_sub_seq dut (
    .clk(clk), .reset_n(reset_n), .dataa(dataa), .datab(datab),
    .enable(enable), .result(result), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: the arithmetic rules for a - b on plain integers.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output int lat);
    logic [31:0] bn;
    int          ea, eb, e, d, n;
    longint      ma, mb, mbig, msml, s;
    logic        sbig;
    bn  = {~b[31], b[30:0]};
    ea  = int'(a[30:23]);
    eb  = int'(b[30:23]);
    lat = 0;
    n   = 0;
    if (ea == 0 && eb == 0)        r = 32'h0;
    else if (eb == 0)              r = a;
    else if (ea == 0)              r = bn;
    else if (ea == 255 || eb == 255) r = 32'h7FC0_0000;
    else begin
      ma = longint'({1'b1, a[22:0]});
      mb = longint'({1'b1, b[22:0]});
      if (a[30:0] >= b[30:0]) begin
        mbig = ma; msml = mb; e = ea; d = ea - eb; sbig = a[31];
      end else begin
        mbig = mb; msml = ma; e = eb; d = eb - ea; sbig = bn[31];
      end
      msml = (d >= 24) ? 0 : (msml >> d);
      s = (a[31] == bn[31]) ? mbig + msml : mbig - msml;
      if (s >= 64'd16777216) begin
        s = s / 2;
        e++;
      end else if (s != 0) begin
        while (s < 64'd8388608) begin
          s = s * 2;
          e--;
          n++;
        end
      end
      lat = 4 + n;
      if (s == 0 || e <= 0) r = 32'h0;
      else if (e >= 255)    r = {sbig, 8'hFF, 23'h0};
      else                  r = {sbig, 8'(e), 23'(s)};
    end
  endfunction

  // Scoreboard: done only on the predicted cycle, result held otherwise.
  initial begin
    forever begin
      @(negedge clk);
      if (cyc == done_cyc) begin
        hold_res = pend_res;
        check($sformatf("done_pulse@%0d", cyc), {31'd0, done}, 32'd1);
      end else begin
        check($sformatf("done_idle@%0d", cyc), {31'd0, done}, 32'd0);
      end
      check($sformatf("result@%0d", cyc), result, hold_res);
    end
  end

  // Called at negedge+1 with the DUT in IDLE; the next edge is edge k.
  task automatic launch(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input int lat, input bit hold_en);
    dataa    = a;
    datab    = b;
    enable   = 1'b1;
    pend_res = res;
    done_cyc = cyc + 1 + lat;
    @(posedge clk);
    @(negedge clk);
    #1;
    if (!hold_en) begin
      enable = 1'b0;
      dataa  = $urandom;
      datab  = $urandom;
    end
  endtask

  task automatic wait_done();
    int budget = 0;
    while (cyc < done_cyc + 1) begin
      @(negedge clk);
      #1;
      budget++;
      if (budget > 100) begin
        checks++;
        failures++;
        $display("FAIL wait_done: timed out at cycle %0d, done expected at %0d", cyc, done_cyc);
        done_cyc = -1;
        break;
      end
    end
  endtask

  // Directed vector: pins the model against a hand-computed value, then runs it.
  task automatic run_lit(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input int lat);
    logic [31:0] mr;
    int          ml;
    model(a, b, mr, ml);
    check({name, "_model_res"}, mr, res);
    check({name, "_model_lat"}, ml, lat);
    launch(a, b, res, lat, 1'b0);
    wait_done();
  endtask

  task automatic run_model(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] mr;
    int          ml;
    model(a, b, mr, ml);
    launch(a, b, mr, ml, 1'b0);
    wait_done();
  endtask

  initial begin
    int first;
    repeat (2) @(negedge clk);
    #1;
    check("reset_result", result, 32'h0);
    check("reset_done", {31'd0, done}, 32'd0);
    reset_n = 1'b1;

    run_lit("sub_3m1",     32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 4);
    run_lit("carry_1pm1",  32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000, 4);
    run_lit("trunc_n23",   32'h3F80_0000, 32'h3F7F_FFFF, 32'h3400_0000, 27);
    run_lit("a_zero",      32'h0000_0000, 32'h40A0_0000, 32'hC0A0_0000, 0);
    run_lit("cancel",      32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 4);
    run_lit("inf_a",       32'h7F80_0000, 32'h3F80_0000, 32'h7FC0_0000, 0);
    run_lit("b_zero",      32'h4040_0000, 32'h0000_0000, 32'h4040_0000, 0);
    run_lit("both_zero",   32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 0);
    run_lit("neg_1m3",     32'h3F80_0000, 32'h4040_0000, 32'hC000_0000, 4);
    run_lit("add_path",    32'h3FC0_0000, 32'hC010_0000, 32'h4070_0000, 4);
    run_lit("diff_ge24",   32'h4B80_0000, 32'h3F80_0000, 32'h4B80_0000, 4);
    run_lit("overflow",    32'h7F7F_FFFF, 32'hFF7F_FFFF, 32'h7F80_0000, 4);
    run_lit("underflow",   32'h0080_0000, 32'h00C0_0000, 32'h0000_0000, 5);
    run_lit("nan_b",       32'h3F80_0000, 32'h7FC0_0001, 32'h7FC0_0000, 0);

    // enable pulse while the long operation sits in NORM must be ignored
    launch(32'h3F80_0000, 32'h3F7F_FFFF, 32'h3400_0000, 27, 1'b0);
    repeat (7) begin @(negedge clk); #1; end
    dataa  = 32'h4040_0000;
    datab  = 32'h3F80_0000;
    enable = 1'b1;
    @(negedge clk); #1;
    enable = 1'b0;
    wait_done();

    // enable held high restarts on the first IDLE cycle after DONE
    launch(32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 4, 1'b1);
    while (cyc < done_cyc) begin @(negedge clk); #1; end
    first    = done_cyc;
    done_cyc = first + 6;
    repeat (2) begin @(negedge clk); #1; end
    enable = 1'b0;
    wait_done();

    // reset during NORM aborts the operation with no done pulse
    launch(32'h3F80_0000, 32'h3F7F_FFFF, 32'h3400_0000, 27, 1'b0);
    repeat (10) begin @(negedge clk); #1; end
    reset_n = 1'b0;
    #1;
    check("abort_result", result, 32'h0);
    check("abort_done", {31'd0, done}, 32'd0);
    hold_res = 32'h0;
    done_cyc = -1;
    @(negedge clk); #1;
    reset_n = 1'b1;
    run_lit("after_reset", 32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 4);

    for (int i = 0; i < 16; i++) run_model($urandom, $urandom);
    for (int i = 0; i < 8; i++)
      run_model({$urandom_range(0, 1) == 1, 8'd127, 23'($urandom)},
                {$urandom_range(0, 1) == 1, 8'($urandom_range(110, 135)), 23'($urandom)});

    repeat (3) @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
